// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART serial receiver. Recovers start/data/[parity]/stop
//               frames from an asynchronous rx line and hands each received
//               word to the consumer through a single-entry valid/ready
//               output register that carries framing and parity error flags.
//               Bit timing comes from a per-state sample counter that is
//               cleared on every state entry. Sampling is therefore
//               phase-aligned to each start edge rather than to a
//               free-running baud tick.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1          system clock, rising-edge active
//   reset      in   1          synchronous active-high reset
//   rx         in   1          asynchronous serial input, idles high
//   rx_data    out  DATA_BITS  received word, right-aligned (valid w/ rx_valid)
//   rx_valid   out  1          output register holds an unconsumed frame
//   rx_ready   in   1          consumer accepts when rx_valid & rx_ready
//   frame_err  out  1          stop bit sampled low (qualified by rx_valid)
//   parity_err out  1          parity mismatch (qualified by rx_valid)
//   overrun    out  1          one-cycle pulse: completed frame dropped
//   busy       out  1          receiver FSM is not idle
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_BW = $clog2(DATA_BITS);

    // Terminal counts: half a bit to reach the middle of the start bit,
    // then a full bit period to reach the middle of every following bit.
    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS - 1);
    localparam logic            c_PEN  = (PARITY_EN != 0);
    localparam logic            c_PODD = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rx_s;

    logic [c_CW-1:0]       r_cnt;
    logic                  w_strobe;
    logic                  w_counting;
    logic                  w_entry;

    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_pend;
    logic                  w_par_exp;

    logic                  w_commit;
    logic                  w_load;

    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_perr;
    logic                  r_ovr;

    // ------------------------------------------------------------------
    // Two-flop synchronizer. Resets to the idle (high) line level so that
    // leaving reset never looks like a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------
    // Sample strobe: fires on the terminal count of the current state.
    // ------------------------------------------------------------------
    always_comb begin
        w_strobe   = 1'b0;
        w_counting = 1'b0;
        case (r_state)
            S_START: begin
                w_counting = 1'b1;
                w_strobe   = (r_cnt == c_HALF_M1);
            end
            S_DATA, S_PARITY, S_STOP: begin
                w_counting = 1'b1;
                w_strobe   = (r_cnt == c_FULL_M1);
            end
            default: begin
                w_counting = 1'b0;
                w_strobe   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                // A line that is back high at mid-start-bit was a glitch.
                if (w_strobe) begin
                    w_next = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_strobe && (r_bit_cnt == c_LAST_BIT)) begin
                    w_next = c_PEN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_strobe) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                // A low stop bit may be a break condition; wait it out so the
                // held-low line is not mistaken for a stream of start bits.
                if (w_strobe) begin
                    w_next = w_rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_entry = (w_next != r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Sample counter. Cleared on state entry and on each strobe so that
    // consecutive data bits stay exactly one bit period apart.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_entry || w_strobe) begin
            r_cnt <= '0;
        end else if (w_counting) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Data path: bit counter, shift register, pending parity error
    // ------------------------------------------------------------------
    assign w_par_exp = (^r_shift) ^ c_PODD;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_pend <= 1'b0;
        end else begin
            if (w_entry) begin
                r_bit_cnt <= '0;
            end else if ((r_state == S_DATA) && w_strobe) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            // LSB arrives first: shift right, new bit enters at the MSB.
            // After DATA_BITS shifts the word is right-aligned.
            if ((r_state == S_DATA) && w_strobe) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end

            if ((r_state == S_IDLE) && (w_next == S_START)) begin
                r_par_pend <= 1'b0;
            end else if (c_PEN && (r_state == S_PARITY) && w_strobe &&
                         (w_rx_s != w_par_exp)) begin
                r_par_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register. A frame is committed at the stop-bit strobe; it is
    // accepted if the register is empty or being drained in the same cycle,
    // otherwise it is dropped and overrun pulses.
    // ------------------------------------------------------------------
    assign w_commit = (r_state == S_STOP) && w_strobe;
    assign w_load   = w_commit && (!r_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_commit && !w_load;
            if (w_load) begin
                r_data  <= r_shift;
                r_ferr  <= !w_rx_s;
                r_perr  <= r_par_pend;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive path of the UART; the counterpart of the TX_Out transmitter.
- Recovers 8N1 frames (optional parity) from the asynchronous rx line.
- Uses its own per-bit clock-enable counter rather than a free-running ticker, so sampling is phase-aligned to each start edge.
- Delivers bytes through a single-entry valid/ready output register with error flags.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); must be >= 8.
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  DATA_BITS  received byte, right-aligned; valid while rx_valid = 1.
- rx_valid  out  1  output register holds an unconsumed frame.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid & rx_ready.
- frame_err  out  1  stop bit sampled low for the frame in rx_data; qualified by rx_valid.
- parity_err  out  1  parity mismatch for the frame in rx_data; qualified by rx_valid; always 0 if PARITY_EN = 0.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the output register was still full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- **Reset.** Synchronous, active-high. It dominates all other activity, including mid-frame, where the partial frame is discarded.
  - Two-flop synchronizer resets to 1.
  - FSM resets to IDLE; bit counter and sample counter reset to 0.
  - rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
- **Synchronizer.** rx passes through a two-flop synchronizer; rx_s is its output. All FSM decisions use rx_s only.
- **Sample counter.** Counts 0..limit-1 and produces a sample strobe at the terminal count.
  - limit = CLKS_PER_BIT/2 (integer divide) in START.
  - limit = CLKS_PER_BIT in DATA, PARITY and STOP.
  - Cleared on every state entry.
- **Timing reference.** T0 = the first cycle in IDLE with rx_s = 0. Let H = CLKS_PER_BIT/2 and P = PARITY_EN.
  - Start sample: T0 + H.
  - Data bit i (i = 0..DATA_BITS-1): T0 + H + (i+1)·CLKS_PER_BIT.
  - Parity sample: T0 + H + (DATA_BITS+1)·CLKS_PER_BIT.
  - Stop sample: T0 + H + (DATA_BITS+1+P)·CLKS_PER_BIT.
- **FSM states and transitions.**
  - IDLE: when rx_s = 0, go to START.
  - START: at the strobe, if rx_s = 0 go to DATA; if rx_s = 1 it is a false start (glitch), so return to IDLE with no output and no flags.
  - DATA: at each strobe, shift rx_s into the MSB of the shift register (right shift, LSB first) and increment the bit counter. After DATA_BITS samples, go to PARITY if P = 1, otherwise to STOP.
  - PARITY: at the strobe, compute expected = XOR(data) XOR PARITY_ODD. A mismatch with rx_s sets the pending parity error. Go to STOP.
  - STOP: at the strobe, rx_s = 0 sets the pending frame error. Then commit the frame (see below).
    - Good stop bit: go directly to IDLE. This allows back-to-back frames with no idle gap.
    - Bad stop bit: go to BREAK.
  - BREAK: stay until rx_s = 1, then go to IDLE.
- **Commit (STOP strobe cycle).**
  - If rx_valid = 0, or rx_valid & rx_ready in the same cycle: load rx_data, frame_err and parity_err. rx_valid = 1 from the next cycle.
  - Otherwise: keep the old contents, drop the new frame, and pulse overrun = 1 for exactly the next cycle.
- **Output handshake.**
  - rx_valid clears the cycle after rx_valid & rx_ready, unless a commit happens in that same cycle, in which case it stays high.
  - rx_data and the error flags are stable while rx_valid = 1.
  - rx_ready is ignored while rx_valid = 0.
- **busy** = (state != IDLE). It covers BREAK.

Test Plan:
- **Single byte.** CLKS_PER_BIT = 16, rx_ready = 1, send 0xA5 8N1 → rx_valid pulses 1 cycle, rx_data = 0xA5, frame_err = 0, parity_err = 0, overrun = 0. rx_valid rises at T0 + 8 + 144 + 1.
- **False start.** rx low for 4 cycles then high → FSM returns to IDLE; rx_valid stays 0; busy high for at most 8 cycles.
- **Framing error, then recovery.** Send 0x3C with stop bit = 0, then hold rx low 100 cycles, then send 0x81 → first frame: rx_data = 0x3C, frame_err = 1, busy high through the low period. Then rx_data = 0x81, frame_err = 0.
- **Overrun.** rx_ready = 0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11; overrun pulses 1 cycle at the 0x22 stop sample. After rx_ready = 1, rx_valid drops and no 0x22 appears.
- **Parity.** PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 0 → parity_err = 1. Resend 0x07 with parity bit 1 → parity_err = 0.
- **Reset mid-frame.** Assert reset at data bit 3 of 0xFF, release, then send 0x5A → no output for the aborted frame; next rx_data = 0x5A with no errors.
